in_and_out_mem_arbiter: RTL and testbench



---
 rtl/in_and_out_mem_arbiter_pkg.sv | 21 ++
 rtl/in_and_out_mem_arbiter_rr_arb2.sv | 18 +
 rtl/in_and_out_mem_arbiter.sv | 111 +++++++++++
 tb/tb_in_and_out_mem_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/in_and_out_mem_arbiter_pkg.sv
// Shared types for the in/out storage arbiter: address/data types, FSM states, request bundle.
package in_and_out_mem_arbiter_pkg;

    typedef logic [4:0] bSizeT;
    typedef logic [6:0] dSt;

    localparam int unsigned MEM_DEPTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_MEM_RD,
        ARB_RSP
    } arbStateT;

    typedef struct packed {
        logic  write;
        bSizeT index;
        dSt    wdata;
    } memReqSt;

endpackage

// File: rtl/in_and_out_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

endmodule

// File: rtl/in_and_out_mem_arbiter.sv
// Two-requester arbiter for a single-port 32 x dSt array with 1-cycle read latency.
// Optional INANDOUT_ARB_STATS_EN adds per-requester saturating grant counters.
module in_and_out_mem_arbiter
    import in_and_out_mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef INANDOUT_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [1:0][15:0]  grant_cnt,
`endif
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  bSizeT [1:0]       req_index,
    input  dSt    [1:0]       req_wdata,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output dSt                rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output bSizeT             mem_addr,
    output dSt                mem_wdata,
    input  dSt                mem_rdata
);

    if ((NUM_REQ != 2) || (MEM_DEPTH != 2 ** $bits(bSizeT))) begin : g_bad_cfg
        $error("in_and_out_mem_arbiter: unsupported NUM_REQ/MEM_DEPTH");
    end

    arbStateT   state_q, state_d;
    logic       owner_q;
    logic       last_grant_q;
    logic [1:0] rsp_valid_q;
    dSt         rsp_data_q;

    logic [1:0] grant;
    logic       win;
    logic       accept;
    memReqSt    req_sel;

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        win     = grant[1];
        req_sel = '{write: req_write[win], index: req_index[win], wdata: req_wdata[win]};
        accept  = !rst && (state_q == ARB_IDLE) && (grant != 2'b00);

        req_ready = accept ? grant : 2'b00;
        mem_en    = accept;
        mem_we    = accept && req_sel.write;
        mem_addr  = req_sel.index;
        mem_wdata = req_sel.wdata;

        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (accept && !req_sel.write) state_d = ARB_MEM_RD;
            ARB_MEM_RD: state_d = ARB_RSP;
            ARB_RSP:    if (rsp_ready[owner_q]) state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= win;
                owner_q      <= win;
            end
            if (state_q == ARB_MEM_RD) begin
                rsp_data_q           <= mem_rdata;
                rsp_valid_q[owner_q] <= 1'b1;
            end
            if ((state_q == ARB_RSP) && rsp_ready[owner_q]) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef INANDOUT_ARB_STATS_EN
    logic [1:0][15:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            grant_cnt_q <= '0;
        end else if (accept && (grant_cnt_q[win] != 16'hFFFF)) begin
            grant_cnt_q[win] <= grant_cnt_q[win] + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_in_and_out_mem_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a transaction-level model.
module tb_in_and_out_mem_arbiter;
    import in_and_out_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_write;
    bSizeT [1:0] req_index;
    dSt    [1:0] req_wdata;
    logic [1:0]  rsp_valid, rsp_ready;
    dSt          rsp_data;
    logic        mem_en, mem_we;
    bSizeT       mem_addr;
    dSt          mem_wdata, mem_rdata;

    int unsigned checks = 0;
    int unsigned failures = 0;

    in_and_out_mem_arbiter #(.NUM_REQ(2), .MEM_DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_index (req_index),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Storage the arbiter drives: single port, registered read data.
    dSt mem_arr [32];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_addr];
    end

    // Reference model: golden contents, last winner, one outstanding read.
    dSt          gold [32];
    int          last_w;
    bit          pend;
    int          pend_owner;
    int          pend_age;
    dSt          pend_data;
    dSt          exp_rsp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [1:0] wr,
                        input bSizeT i0, input bSizeT i1, input dSt d0, input dSt d1,
                        input logic [1:0] rr);
        int   w;
        bit   acc;
        logic [1:0] exp_rv;
        @(negedge clk);
        rst = r; req_valid = v; req_write = wr;
        req_index[0] = i0; req_index[1] = i1;
        req_wdata[0] = d0; req_wdata[1] = d1;
        rsp_ready = rr;
        #1;
        if (v == 2'b01) w = 0;
        else if (v == 2'b10) w = 1;
        else w = 1 - last_w;
        acc = !r && !pend && (v != 2'b00);

        check("req_ready", 32'(req_ready), acc ? 32'(1 << w) : 32'd0);
        check("mem_en", 32'(mem_en), 32'(acc));
        check("mem_we", 32'(mem_we), 32'(acc && wr[w]));
        if (acc) begin
            check("mem_addr", 32'(mem_addr), 32'(w ? i1 : i0));
            if (wr[w]) check("mem_wdata", 32'(mem_wdata), 32'(w ? d1 : d0));
        end
        exp_rv = (pend && pend_age == 2) ? 2'(1 << pend_owner) : 2'b00;
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rsp_data", 32'(rsp_data), 32'(exp_rsp));

        if (r) begin
            pend = 0; last_w = 1; exp_rsp = '0;
        end else begin
            if (pend && pend_age == 2 && rr[pend_owner]) pend = 0;
            else if (pend && pend_age == 1) begin
                pend_age = 2; exp_rsp = pend_data;
            end
            if (acc) begin
                last_w = w;
                if (wr[w]) gold[w ? i1 : i0] = w ? d1 : d0;
                else begin
                    pend = 1; pend_owner = w; pend_age = 1;
                    pend_data = gold[w ? i1 : i0];
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_arr[i] = '0;
            gold[i] = '0;
        end
        mem_rdata = '0;
        last_w = 1; pend = 0; pend_owner = 0; pend_age = 0; pend_data = '0; exp_rsp = '0;
        rst = 1'b1; req_valid = '0; req_write = '0; req_index = '0; req_wdata = '0; rsp_ready = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state, then write idx 5 and read it back.
        step(1, 2'b11, 2'b11, 5'd1, 5'd2, 7'h11, 7'h22, 2'b11);
        step(0, 2'b01, 2'b01, 5'd5, 5'd0, 7'h2A, 7'h00, 2'b11);
        step(0, 2'b01, 2'b00, 5'd5, 5'd0, 7'h00, 7'h00, 2'b11);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b11);

        // Contention after reset: 4 back-to-back writes from both sides.
        step(1, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b00);
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, 2'b11, 5'(8 + i), 5'(16 + i), 7'(i), 7'(7'h40 + i), 2'b00);

        // Backpressure on a req1 read while req0 keeps requesting.
        step(0, 2'b10, 2'b00, 5'd0, 5'd17, 7'h0, 7'h0, 2'b00);
        for (int i = 0; i < 7; i++) step(0, 2'b01, 2'b00, 5'd8, 5'd0, 7'h0, 7'h0, 2'b01);
        step(0, 2'b01, 2'b00, 5'd8, 5'd0, 7'h0, 7'h0, 2'b10);
        step(0, 2'b01, 2'b00, 5'd8, 5'd0, 7'h0, 7'h0, 2'b11);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b11);

        // Reset during the memory read cycle drops the response.
        step(0, 2'b01, 2'b00, 5'd5, 5'd0, 7'h0, 7'h0, 2'b11);
        step(1, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b11);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b11);

        // Highest index.
        step(0, 2'b10, 2'b10, 5'd0, 5'd31, 7'h0, 7'h7F, 2'b11);
        step(0, 2'b01, 2'b00, 5'd31, 5'd0, 7'h0, 7'h0, 2'b11);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 5'd0, 5'd0, 7'h0, 7'h0, 2'b11);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 2'($urandom), 2'($urandom),
                 5'($urandom), 5'($urandom), 7'($urandom), 7'($urandom),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
